// File: rtl/bcd_serial_counter.sv
// Serial BCD counter: one shared digit incrementer walks the digits LSD-first,
// one digit per clock, stopping as soon as the carry dies out.
module bcd_serial_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inc_req,
  input  logic                  clr,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   digits,
  output logic [1:0]            state_dbg
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;

  logic [3:0]          cur_digit;
  logic [4:0]          sum;
  logic [3:0]          new_digit;
  logic                carry_out;

  // Handshake: inc_req is a level sampled only in IDLE; busy marks RUN and
  // done is a single-cycle pulse in DONE. Requests seen elsewhere are dropped.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_digit = digits_q[4*i +: 4];
    end
    // 5-bit sum so the >= 10 compare never sees a truncated value
    sum = {1'b0, cur_digit} + {4'd0, carry_q};
    if (sum >= 5'd10) begin
      new_digit = 4'd0;
      carry_out = 1'b1;
    end else begin
      new_digit = sum[3:0];
      carry_out = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (inc_req) begin
          idx_d   = '0;
          carry_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) digits_d[4*i +: 4] = new_digit;
        end
        carry_d = carry_out;
        if (!carry_out) begin
          state_d = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d  = S_IDLE;
      digits_d = '0;
      idx_d    = '0;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign ovf       = ovf_q;
  assign digits    = digits_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_serial_counter.sv
// Directed bench for bcd_serial_counter (DIGITS=4): reset, single step,
// carry ripple, wrap/overflow, abort by clr and by reset, hold-and-drop.
module tb_bcd_serial_counter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inc_req;
  logic        clr;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] digits;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  bcd_serial_counter #(.DIGITS(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inc_req   (inc_req),
    .clr       (clr),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .digits    (digits),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold inc_req until a done pulse shows the target value, then drop it
  // during DONE so no further request is accepted. Leaves the DUT in DONE.
  task automatic count_to(input logic [15:0] target);
    bit hit = 0;
    inc_req = 1'b1;
    for (int n = 0; n < 40000; n++) begin
      tick();
      if (done && digits == target) begin
        hit = 1;
        break;
      end
    end
    inc_req = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL count_to timeout: digits=%h required=%h", digits, target);
    end
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    inc_req = 1'b1;
    clr     = 1'b0;
    repeat (2) tick();
    checks++;
    if (digits !== 16'h0000 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: digits=%h ovf=%b busy=%b done=%b st=%0d required 0000/0/0/0/0",
               digits, ovf, busy, done, state_dbg);
    end
    inc_req = 1'b0;
    resetn  = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: busy=%b digits=%h required 0/0000", busy, digits);
    end
  endtask

  task automatic test_single_step();
    inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: busy=%b done=%b required 1/0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || digits !== 16'h0001 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b done=%b digits=%h ovf=%b required 0/1/0001/0",
               busy, done, digits, ovf);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_carry_ripple();
    logic [15:0] exp_mid [3] = '{16'h0099, 16'h0090, 16'h0000};
    count_to(16'h0099);
    tick();
    inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || digits !== exp_mid[i]) begin
        errors++;
        $display("FAIL ripple_step%0d: busy=%b done=%b digits=%h required 1/0/%h",
                 i, busy, done, digits, exp_mid[i]);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || digits !== 16'h0100 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ripple_done: busy=%b done=%b digits=%h ovf=%b required 0/1/0100/0",
               busy, done, digits, ovf);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL ripple_done_width: done=%b required 0", done);
    end
  endtask

  task automatic test_wrap();
    count_to(16'h9999);
    tick();
    inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL wrap_busy%0d: busy=%b done=%b ovf=%b required 1/0/0", i, busy, done, ovf);
      end
      tick();
    end
    checks++;
    if (digits !== 16'h0000 || done !== 1'b1 || ovf !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: digits=%h done=%b ovf=%b busy=%b required 0000/1/1/0",
               digits, done, ovf, busy);
    end
    tick();
    inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    tick();
    checks++;
    if (digits !== 16'h0001 || ovf !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky: digits=%h ovf=%b done=%b required 0001/1/1", digits, ovf, done);
    end
    tick();
  endtask

  task automatic test_abort(input bit use_reset, input logic exp_ovf_before);
    count_to(16'h0999);
    tick();
    inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || digits !== 16'h0990 || ovf !== exp_ovf_before) begin
      errors++;
      $display("FAIL abort_pre(rst=%0d): busy=%b digits=%h ovf=%b required 1/0990/%b",
               use_reset, busy, digits, ovf, exp_ovf_before);
    end
    if (use_reset) resetn = 1'b0;
    else           clr    = 1'b1;
    tick();
    resetn = 1'b1;
    clr    = 1'b0;
    checks++;
    if (digits !== 16'h0000 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear(rst=%0d): digits=%h ovf=%b busy=%b done=%b required 0000/0/0/0",
               use_reset, digits, ovf, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || digits !== 16'h0000) begin
        errors++;
        $display("FAIL abort_quiet(rst=%0d,%0d): done=%b busy=%b digits=%h required 0/0/0000",
                 use_reset, i, done, busy, digits);
      end
    end
  endtask

  task automatic test_hold_and_drop();
    int dcount = 0;
    inc_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    inc_req = 1'b0;
    checks++;
    if (digits !== 16'h0010 || dcount != 10) begin
      errors++;
      $display("FAIL hold_count: digits=%h dones=%0d required 0010/10", digits, dcount);
    end
    repeat (3) tick();
    checks++;
    if (digits !== 16'h0010 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_settle: digits=%h busy=%b done=%b required 0010/0/0", digits, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_carry_ripple();
    test_wrap();
    test_abort(1'b0, 1'b1);
    test_abort(1'b1, 1'b0);
    test_hold_and_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
